instr_fetch_ctrl: RTL and testbench

- Fetch/sequencing controller directly downstream of the program counter.
- Consumes the counter's current address and reads the instruction word from program memory over a REQ/ACK handshake. Latches the word into the instruction register.
- Resolves control-flow opcodes locally. Drives the counter's load-address, load-select and advance strobe; issues all other instructions to the execute stage over a VALID/READY handshake.

---
 rtl/instr_fetch_ctrl_pkg.sv | 20 ++
 rtl/instr_fetch_ctrl_branch_resolve.sv | 40 ++++
 rtl/instr_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared opcode, state and width constants for the instruction fetch/sequencing controller.
package instr_fetch_ctrl_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_OP_W   = 3;

  localparam logic [DEF_OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [DEF_OP_W-1:0] OP_JMP = 3'b001;
  localparam logic [DEF_OP_W-1:0] OP_JZ  = 3'b010;
  localparam logic [DEF_OP_W-1:0] OP_JNZ = 3'b011;
  localparam logic [DEF_OP_W-1:0] OP_HLT = 3'b111;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_ADV    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

endpackage

// File: rtl/instr_fetch_ctrl_branch_resolve.sv
// Combinational opcode classifier: decides branch/halt/execute class and whether a branch is taken.
module branch_resolve
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int OP_W = DEF_OP_W
) (
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            is_branch,
  output logic            taken,
  output logic            is_halt,
  output logic            is_exec
);

  // NOP is neither a branch nor execute-class; it simply advances the counter.
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    is_halt   = 1'b0;
    is_exec   = 1'b0;
    case (opcode)
      OP_NOP: is_branch = 1'b0;
      OP_JMP: begin
        is_branch = 1'b1;
        taken     = 1'b1;
      end
      OP_JZ: begin
        is_branch = 1'b1;
        taken     = zero;
      end
      OP_JNZ: begin
        is_branch = 1'b1;
        taken     = ~zero;
      end
      OP_HLT:  is_halt = 1'b1;
      default: is_exec = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/sequencing controller: fetches from program memory, resolves control flow locally,
// strobes the program counter and hands execute-class instructions to the execute stage.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              CLOCK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC_ADDR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_REQ,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_ADDR,
  output logic              LOAD,
  output logic              PC_ADV,
  output logic              EX_VALID,
  input  logic              EX_READY,
  input  logic              ZERO,
  output logic              HALTED
);

  logic [2:0]      state;
  logic            req_armed;
  logic [OP_W-1:0] opcode;
  logic            is_branch;
  logic            taken;
  logic            is_halt;
  logic            is_exec;

  assign opcode   = IR[DATA_W-1 -: OP_W];
  assign MEM_ADDR = PC_ADDR;
  assign IR_ADDR  = IR[ADDR_W-1:0];

  // The request stays low while in reset and rises on the first edge after release,
  // so a late ACK from an abandoned read can never be captured.
  assign MEM_REQ  = (state == S_FETCH) && req_armed;
  assign EX_VALID = (state == S_ISSUE);
  assign PC_ADV   = (state == S_ADV);
  assign HALTED   = (state == S_HALT);

  branch_resolve #(
    .OP_W(OP_W)
  ) u_branch_resolve (
    .opcode   (opcode),
    .zero     (ZERO),
    .is_branch(is_branch),
    .taken    (taken),
    .is_halt  (is_halt),
    .is_exec  (is_exec)
  );

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      req_armed <= 1'b0;
    end else begin
      req_armed <= 1'b1;
    end
  end

  // LOAD is only ever set in DECODE and is cleared on every path into FETCH.
  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_FETCH;
      IR    <= '0;
      LOAD  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (MEM_REQ && MEM_ACK) begin
            IR    <= MEM_DATA;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_halt) begin
            state <= S_HALT;
          end else if (is_exec) begin
            state <= S_ISSUE;
          end else begin
            LOAD  <= is_branch & taken;
            state <= S_ADV;
          end
        end
        S_ISSUE: begin
          if (EX_READY) begin
            LOAD  <= 1'b0;
            state <= S_ADV;
          end
        end
        S_ADV: begin
          LOAD  <= 1'b0;
          state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          LOAD  <= 1'b0;
          state <= S_FETCH;
        end
      endcase
    end
  end

  strobes_exclusive: assert property (@(posedge CLOCK) disable iff (!RST_N)
    $onehot0({MEM_REQ, EX_VALID, PC_ADV, HALTED}));

  issue_held: assert property (@(posedge CLOCK) disable iff (!RST_N)
    (EX_VALID && !EX_READY) |=> EX_VALID);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: program memory, counter and execute-stage responders plus a
// transaction-level scoreboard that predicts every cycle's outputs from each fetched word.
module tb_instr_fetch_ctrl;

  typedef struct {
    logic req;
    logic valid;
    logic adv;
    logic halt;
    logic load;
  } exp_t;

  logic        CLOCK = 1'b0;
  logic        RST_N = 1'b1;
  logic [12:0] PC_ADDR = '0;
  logic [12:0] MEM_ADDR;
  logic        MEM_REQ;
  logic        MEM_ACK = 1'b0;
  logic [15:0] MEM_DATA = '0;
  logic [15:0] IR;
  logic [12:0] IR_ADDR;
  logic        LOAD;
  logic        PC_ADV;
  logic        EX_VALID;
  logic        EX_READY = 1'b0;
  logic        ZERO = 1'b0;
  logic        HALTED;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] prog [0:8191];
  exp_t        exp_q[$];
  logic        model_halted = 1'b0;
  logic [12:0] exp_fetch_addr = '0;
  logic [15:0] cur_word = '0;
  logic [12:0] start_pc = '0;
  int          mem_wait = 0;
  int          ex_wait = 0;
  int          req_count = 0;
  int          ex_count = 0;

  always #5 CLOCK = ~CLOCK;

  instr_fetch_ctrl dut (
    .CLOCK   (CLOCK),
    .RST_N   (RST_N),
    .PC_ADDR (PC_ADDR),
    .MEM_ADDR(MEM_ADDR),
    .MEM_REQ (MEM_REQ),
    .MEM_ACK (MEM_ACK),
    .MEM_DATA(MEM_DATA),
    .IR      (IR),
    .IR_ADDR (IR_ADDR),
    .LOAD    (LOAD),
    .PC_ADV  (PC_ADV),
    .EX_VALID(EX_VALID),
    .EX_READY(EX_READY),
    .ZERO    (ZERO),
    .HALTED  (HALTED)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t mk(input logic req, input logic valid, input logic adv, input logic halt, input logic load);
    exp_t e;
    e.req = req; e.valid = valid; e.adv = adv; e.halt = halt; e.load = load;
    return e;
  endfunction

  // Once a word is delivered: one quiet decode cycle, then issue/advance/halt per the opcode.
  task automatic model_accept(input logic [12:0] addr, input logic [15:0] word);
    logic [2:0]  op;
    logic [12:0] target;
    logic        take;
    op       = word[15:13];
    target   = word[12:0];
    cur_word = word;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_fetch_addr = addr + 13'd1;
    case (op)
      3'b111: model_halted = 1'b1;
      3'b100, 3'b101, 3'b110: begin
        for (int i = 0; i <= ex_wait; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      default: begin
        take = (op == 3'b001) || (op == 3'b010 && ZERO) || (op == 3'b011 && !ZERO);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, take));
        if (take) exp_fetch_addr = target;
      end
    endcase
  endtask

  // Environment + scoreboard: compare, then step the counter, then answer memory and execute.
  always @(negedge CLOCK) begin
    exp_t e;
    if (!RST_N) begin
      exp_q.delete();
      model_halted   = 1'b0;
      PC_ADDR        = start_pc;
      exp_fetch_addr = start_pc;
      req_count      = 0;
      ex_count       = 0;
      MEM_ACK        = 1'b0;
      EX_READY       = 1'b0;
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else if (model_halted) e = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_output("MEM_REQ", {31'd0, MEM_REQ}, {31'd0, e.req});
      check_output("EX_VALID", {31'd0, EX_VALID}, {31'd0, e.valid});
      check_output("PC_ADV", {31'd0, PC_ADV}, {31'd0, e.adv});
      check_output("HALTED", {31'd0, HALTED}, {31'd0, e.halt});
      check_output("LOAD", {31'd0, LOAD}, {31'd0, e.load});
      if (e.req) check_output("MEM_ADDR", {19'd0, MEM_ADDR}, {19'd0, exp_fetch_addr});
      else check_output("IR", {16'd0, IR}, {16'd0, cur_word});
      if (e.adv) check_output("IR_ADDR", {19'd0, IR_ADDR}, {19'd0, cur_word[12:0]});

      if (PC_ADV) PC_ADDR = LOAD ? IR_ADDR : PC_ADDR + 13'd1;

      MEM_ACK  = 1'b0;
      EX_READY = 1'b0;
      MEM_DATA = 16'hDEAD;
      if (MEM_REQ) begin
        if (req_count >= mem_wait) begin
          MEM_ACK   = 1'b1;
          MEM_DATA  = prog[MEM_ADDR];
          model_accept(MEM_ADDR, prog[MEM_ADDR]);
          req_count = 0;
        end else begin
          req_count++;
        end
      end
      if (EX_VALID) begin
        if (ex_count >= ex_wait) begin
          EX_READY = 1'b1;
          ex_count = 0;
        end else begin
          ex_count++;
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [12:0] pc, input int mw, input int ew, input logic z);
    @(negedge CLOCK); #2;
    RST_N    = 1'b0;
    start_pc = pc;
    mem_wait = mw;
    ex_wait  = ew;
    ZERO     = z;
    @(negedge CLOCK); #2;
    RST_N = 1'b1;
  endtask

  task automatic run_to_adv(output int ex_cycles, output logic load, output logic [12:0] ir_addr,
                            output logic [15:0] ir, output logic [12:0] next_addr);
    bit done;
    done = 1'b0;
    ex_cycles = 0; load = 1'b0; ir_addr = '0; ir = '0; next_addr = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLOCK); #1;
      if (EX_VALID) ex_cycles++;
      if (PC_ADV) begin
        load    = LOAD;
        ir_addr = IR_ADDR;
        ir      = IR;
        @(negedge CLOCK); #1;
        next_addr = MEM_ADDR;
        done      = 1'b1;
      end
    end
    check_output("adv_within_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic check_branch(input string tag, input logic [12:0] pc, input logic z,
                              input logic exp_load, input logic [12:0] exp_next);
    int          n;
    logic        ld;
    logic [12:0] ia;
    logic [15:0] ir;
    logic [12:0] nx;
    apply_stimulus(pc, 0, 0, z);
    run_to_adv(n, ld, ia, ir, nx);
    check_output({tag, "_load"}, {31'd0, ld}, {31'd0, exp_load});
    check_output({tag, "_ir_addr"}, {19'd0, ia}, {19'd0, prog[pc][12:0]});
    check_output({tag, "_next_fetch"}, {19'd0, nx}, {19'd0, exp_next});
  endtask

  initial begin
    int          n;
    int          seen;
    int          bad;
    logic        ld;
    logic [12:0] ia;
    logic [15:0] ir;
    logic [12:0] nx;
    int          adv_idx[$];
    logic [12:0] fetch_list[$];
    logic        prev_req;
    logic [12:0] fetch_exp [3];

    for (int i = 0; i < 8192; i++) prog[i] = 16'h0000;
    prog[13'h0100] = 16'h8005;
    prog[13'h0200] = 16'h3ABC;
    prog[13'h0300] = 16'h4010;
    prog[13'h0400] = 16'h6010;
    prog[13'h0500] = 16'hE000;
    prog[13'h0600] = 16'h2600;
    prog[13'h0700] = 16'hA7FF;

    start_pc = 13'h0100;
    #1 RST_N = 1'b0;
    #1;
    check_output("rst_IR", {16'd0, IR}, 32'd0);
    check_output("rst_LOAD", {31'd0, LOAD}, 32'd0);
    check_output("rst_PC_ADV", {31'd0, PC_ADV}, 32'd0);
    check_output("rst_MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
    check_output("rst_EX_VALID", {31'd0, EX_VALID}, 32'd0);
    check_output("rst_HALTED", {31'd0, HALTED}, 32'd0);

    apply_stimulus(13'h0100, 2, 3, 1'b0);
    run_to_adv(n, ld, ia, ir, nx);
    check_output("exec_ir", {16'd0, ir}, 32'h8005);
    check_output("exec_valid_cycles", n, 32'd4);
    check_output("exec_load", {31'd0, ld}, 32'd0);
    check_output("exec_next_fetch", {19'd0, nx}, 32'h0101);

    apply_stimulus(13'h0100, 0, 10, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge CLOCK); #1;
      if (EX_VALID) seen = 1;
    end
    check_output("reached_issue", seen, 32'd1);
    #1 RST_N = 1'b0;
    #1;
    check_output("midrst_EX_VALID", {31'd0, EX_VALID}, 32'd0);
    check_output("midrst_MEM_REQ", {31'd0, MEM_REQ}, 32'd0);
    check_output("midrst_PC_ADV", {31'd0, PC_ADV}, 32'd0);
    check_output("midrst_IR", {16'd0, IR}, 32'd0);
    @(negedge CLOCK); #2;
    RST_N = 1'b1;
    @(negedge CLOCK); #1;
    check_output("postrst_MEM_REQ", {31'd0, MEM_REQ}, 32'd1);
    check_output("postrst_MEM_ADDR", {19'd0, MEM_ADDR}, 32'h0100);

    check_branch("jmp", 13'h0200, 1'b0, 1'b1, 13'h1ABC);
    check_branch("jz_taken", 13'h0300, 1'b1, 1'b1, 13'h0010);
    check_branch("jz_not", 13'h0300, 1'b0, 1'b0, 13'h0301);
    check_branch("jnz_taken", 13'h0400, 1'b0, 1'b1, 13'h0010);
    check_branch("jnz_not", 13'h0400, 1'b1, 1'b0, 13'h0401);

    apply_stimulus(13'h0700, 0, 0, 1'b0);
    run_to_adv(n, ld, ia, ir, nx);
    check_output("exec101_valid_cycles", n, 32'd1);
    check_output("exec101_next_fetch", {19'd0, nx}, 32'h0701);

    apply_stimulus(13'h0600, 0, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run_to_adv(n, ld, ia, ir, nx);
      check_output($sformatf("selfloop%0d_load", k), {31'd0, ld}, 32'd1);
      check_output($sformatf("selfloop%0d_next", k), {19'd0, nx}, 32'h0600);
    end

    apply_stimulus(13'h0500, 1, 0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge CLOCK); #1;
      if (HALTED) seen = 1;
    end
    check_output("halt_reached", seen, 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK); #1;
      if (MEM_REQ || PC_ADV || !HALTED) bad++;
    end
    check_output("halt_quiet_cycles", bad, 32'd0);
    #1 RST_N = 1'b0;
    #1;
    check_output("halt_cleared_by_reset", {31'd0, HALTED}, 32'd0);

    apply_stimulus(13'h1FFE, 0, 0, 1'b0);
    prev_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLOCK); #1;
      if (PC_ADV) adv_idx.push_back(i);
      if (MEM_REQ && !prev_req) fetch_list.push_back(MEM_ADDR);
      prev_req = MEM_REQ;
    end
    fetch_exp[0] = 13'h1FFE;
    fetch_exp[1] = 13'h1FFF;
    fetch_exp[2] = 13'h0000;
    check_output("tp_adv_count", adv_idx.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("tp_adv_cycle%0d", k), (k < adv_idx.size()) ? adv_idx[k] : -1, 2 + 3 * k);
      check_output($sformatf("tp_fetch%0d", k), (k < fetch_list.size()) ? {19'd0, fetch_list[k]} : 32'hFFFF_FFFF,
                   {19'd0, fetch_exp[k]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by t=%0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
